// File: rtl/ps2_poly_tone_gen.sv
// Polyphonic square-wave tone generator fed by the PS/2 receive byte stream.
// Decodes make / break / extended scan codes, allocates note keys A-G to
// NUM_VOICES oscillators, shifts octave with the up/down arrows and mixes the
// voices into one saturated, registered signed sample.

// One oscillator: holds a note, its latched half-period and a square phase.
module ps2_poly_tone_voice #(
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [2:0]              note_in,
    input  logic [PERIOD_WIDTH-1:0] half_in,
    output logic                    active,
    output logic                    phase,
    output logic [2:0]              note
);
    logic [PERIOD_WIDTH-1:0] half;
    logic [PERIOD_WIDTH-1:0] cnt;

    // Allocation restarts the oscillator; a free voice parks counter and phase at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            phase  <= 1'b0;
            note   <= '0;
            half   <= '0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            phase  <= 1'b0;
            note   <= note_in;
            half   <= half_in;
            cnt    <= '0;
        end else if (stop) begin
            active <= 1'b0;
            phase  <= 1'b0;
            cnt    <= '0;
        end else if (active) begin
            if (cnt == half - PERIOD_WIDTH'(1)) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + PERIOD_WIDTH'(1);
            end
        end
    end
endmodule

module ps2_poly_tone_gen #(
    parameter int CLK_HZ       = 50000000,
    parameter int NUM_VOICES   = 4,
    parameter int AMP_WIDTH    = 32,
    parameter int AMPLITUDE    = 10000000,
    parameter int PERIOD_WIDTH = 24,
    parameter int OCT_MIN      = -4,
    parameter int OCT_MAX      = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [7:0]            ps2_data,
    input  logic                  ps2_data_en,
    output logic [AMP_WIDTH-1:0]  audio_out,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic [3:0]            octave,
    output logic [7:0]            last_code
);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    localparam int SW = AMP_WIDTH + 3;

    // Half-period of each note at octave 0, in clock cycles (A..G).
    localparam logic [PERIOD_WIDTH-1:0] BASE_A = PERIOD_WIDTH'(CLK_HZ / (2 * 440));
    localparam logic [PERIOD_WIDTH-1:0] BASE_B = PERIOD_WIDTH'(CLK_HZ / (2 * 494));
    localparam logic [PERIOD_WIDTH-1:0] BASE_C = PERIOD_WIDTH'(CLK_HZ / (2 * 523));
    localparam logic [PERIOD_WIDTH-1:0] BASE_D = PERIOD_WIDTH'(CLK_HZ / (2 * 587));
    localparam logic [PERIOD_WIDTH-1:0] BASE_E = PERIOD_WIDTH'(CLK_HZ / (2 * 659));
    localparam logic [PERIOD_WIDTH-1:0] BASE_F = PERIOD_WIDTH'(CLK_HZ / (2 * 698));
    localparam logic [PERIOD_WIDTH-1:0] BASE_G = PERIOD_WIDTH'(CLK_HZ / (2 * 784));

    localparam logic signed [3:0] OMIN = 4'(OCT_MIN);
    localparam logic signed [3:0] OMAX = 4'(OCT_MAX);

    localparam logic signed [SW-1:0] AMP_X = SW'(AMPLITUDE);
    localparam logic signed [SW-1:0] SMAX  = SW'((64'sd1 <<< (AMP_WIDTH - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SMIN  = ~SMAX;

    state_t state, state_n;
    logic   do_make, do_rel, oct_up, oct_dn, seq_end;

    logic signed [3:0]       oct_q;
    logic [3:0]              oct_mag;
    logic                    is_note;
    logic [2:0]              note_idx;
    logic [PERIOD_WIDTH-1:0] base_half;
    logic [PERIOD_WIDTH-1:0] half_new;

    logic [NUM_VOICES-1:0]       hit;
    logic [NUM_VOICES-1:0]       free_oh;
    logic [NUM_VOICES-1:0]       alloc;
    logic [NUM_VOICES-1:0]       rel;
    logic [NUM_VOICES-1:0]       phase;
    logic [NUM_VOICES-1:0][2:0]  voice_note;
    logic signed [SW-1:0]        sum;

    assign octave = oct_q;

    // Decoder state register; a reset discards any half-received sequence.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Decoder next state and the single action each sequence-ending byte triggers.
    always_comb begin
        state_n = state;
        do_make = 1'b0;
        do_rel  = 1'b0;
        oct_up  = 1'b0;
        oct_dn  = 1'b0;
        seq_end = 1'b0;
        if (ps2_data_en) begin
            case (state)
                IDLE: begin
                    if (ps2_data == 8'hE0)      state_n = EXT;
                    else if (ps2_data == 8'hF0) state_n = BRK;
                    else begin
                        do_make = 1'b1;
                        seq_end = 1'b1;
                    end
                end
                EXT: begin
                    if (ps2_data == 8'hF0) state_n = EXT_BRK;
                    else begin
                        state_n = IDLE;
                        seq_end = 1'b1;
                        oct_up  = (ps2_data == 8'h75);
                        oct_dn  = (ps2_data == 8'h72);
                    end
                end
                BRK: begin
                    state_n = IDLE;
                    do_rel  = 1'b1;
                    seq_end = 1'b1;
                end
                EXT_BRK: begin
                    // Arrow-key releases carry no meaning.
                    state_n = IDLE;
                    seq_end = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Map scan code to note index A..G and look up its octave-0 half-period.
    always_comb begin
        is_note   = 1'b1;
        note_idx  = 3'd0;
        base_half = BASE_A;
        case (ps2_data)
            8'h1C: begin note_idx = 3'd0; base_half = BASE_A; end
            8'h32: begin note_idx = 3'd1; base_half = BASE_B; end
            8'h21: begin note_idx = 3'd2; base_half = BASE_C; end
            8'h23: begin note_idx = 3'd3; base_half = BASE_D; end
            8'h24: begin note_idx = 3'd4; base_half = BASE_E; end
            8'h2B: begin note_idx = 3'd5; base_half = BASE_F; end
            8'h34: begin note_idx = 3'd6; base_half = BASE_G; end
            default: is_note = 1'b0;
        endcase
    end

    // Octave scaling is a plain shift, so no divider is needed at note-on.
    always_comb begin
        oct_mag = oct_q[3] ? 4'(-oct_q) : 4'(oct_q);
        if (oct_q[3]) half_new = base_half << oct_mag;
        else          half_new = base_half >> oct_mag;
    end

    // Find voices already holding this note and the lowest-index free voice.
    always_comb begin
        hit     = '0;
        free_oh = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            hit[i] = voice_active[i] && (voice_note[i] == note_idx);
            if (!voice_active[i]) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
        end
    end

    // Typematic repeats (note already held) and full voice pools are ignored.
    always_comb begin
        alloc = '0;
        rel   = '0;
        if (do_make && is_note && (hit == '0)) alloc = free_oh;
        if (do_rel && is_note)                 rel   = hit;
    end

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        ps2_poly_tone_voice #(
            .PERIOD_WIDTH(PERIOD_WIDTH)
        ) u_voice (
            .clk    (CLOCK_50),
            .rst    (reset),
            .start  (alloc[i]),
            .stop   (rel[i]),
            .note_in(note_idx),
            .half_in(half_new),
            .active (voice_active[i]),
            .phase  (phase[i]),
            .note   (voice_note[i])
        );
    end

    // Octave shift saturates; last_code tracks the byte that ends each sequence.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            oct_q     <= '0;
            last_code <= '0;
        end else begin
            if (oct_up && (oct_q < OMAX)) oct_q <= oct_q + 4'sd1;
            if (oct_dn && (oct_q > OMIN)) oct_q <= oct_q - 4'sd1;
            if (seq_end)                  last_code <= ps2_data;
        end
    end

    // Mix with three guard bits so that all voices at full swing cannot wrap.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (voice_active[i]) sum = sum + (phase[i] ? AMP_X : -AMP_X);
        end
    end

    // Saturate to the signed output range and register the sample.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)            audio_out <= '0;
        else if (sum > SMAX)  audio_out <= SMAX[AMP_WIDTH-1:0];
        else if (sum < SMIN)  audio_out <= SMIN[AMP_WIDTH-1:0];
        else                  audio_out <= sum[AMP_WIDTH-1:0];
    end
endmodule
